// File: rtl/recepcao_comandos_multinivel_pkg.sv
// Shared types and constants for the multi-level command receiver.
// Optional feature macro: RECEPCAO_CHECKSUM_EN (adds a 4th checksum byte per frame).
package recepcao_comandos_multinivel_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned PAYLOAD_W = 6;
  localparam int unsigned VALOR_W   = 2 * PAYLOAD_W;

  // Frame FSM encoding, also exported on db_estado
  typedef enum logic [1:0] {
    OCIOSO     = 2'd0,
    DADO_ALTO  = 2'd1,
    DADO_BAIXO = 2'd2,
    CHECKSUM   = 2'd3
  } estado_t;

  // UART receiver FSM encoding
  typedef enum logic [1:0] {
    RX_OCIOSO = 2'd0,
    RX_INICIO = 2'd1,
    RX_DADOS  = 2'd2,
    RX_PARADA = 2'd3
  } rx_estado_t;

  typedef enum logic [1:0] {
    BYTE_HDR   = 2'd0,
    BYTE_DADO  = 2'd1,
    BYTE_INVAL = 2'd2
  } classe_t;

  localparam logic             HDR_MARK     = 1'b1;
  localparam logic [5:0]       IDX_MODO     = 6'd63;
  localparam logic [BYTE_W-1:0] MASK_CLASSE = 8'hC0;
  localparam logic [BYTE_W-1:0] MASK_CK     = 8'h7F;
  localparam logic [BYTE_W-1:0] CLASSE_HDR  = 8'h80;
  localparam logic [BYTE_W-1:0] CLASSE_DADO = 8'h00;

  // Header = 10xxxxxx, data = 00xxxxxx, anything with bit6 set is invalid
  function automatic classe_t classifica_byte(input logic [BYTE_W-1:0] b);
    logic [BYTE_W-1:0] c;
    classe_t           r;
    c = b & MASK_CLASSE;
    if (c == CLASSE_HDR)       r = BYTE_HDR;
    else if (c == CLASSE_DADO) r = BYTE_DADO;
    else                       r = BYTE_INVAL;
    return r;
  endfunction

endpackage

// File: rtl/recepcao_comandos_multinivel_rx_serial_8N1.sv
// 8N1 UART receiver: samples each bit at its middle, pulses pronto for one
// cycle with the received byte when a valid stop bit is seen.
module rx_serial_8N1
  import recepcao_comandos_multinivel_pkg::*;
#(
  parameter int unsigned CICLOS_POR_BIT = 434
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              RX,
  output logic              pronto,
  output logic [BYTE_W-1:0] dados_ascii
);

  localparam int unsigned      CNT_W    = (CICLOS_POR_BIT > 2) ? $clog2(CICLOS_POR_BIT) : 1;
  localparam logic [CNT_W-1:0] FIM_BIT  = CNT_W'(CICLOS_POR_BIT - 1);
  localparam logic [CNT_W-1:0] MEIO_BIT = CNT_W'(CICLOS_POR_BIT / 2 - 1);

  rx_estado_t        estado_q, estado_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic              pronto_q, pronto_d;
  logic [BYTE_W-1:0] dados_q, dados_d;
  logic              rx_s1_q, rx_s2_q;

  // State, synchroniser and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= RX_OCIOSO;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      pronto_q <= 1'b0;
      dados_q  <= '0;
      rx_s1_q  <= 1'b1;
      rx_s2_q  <= 1'b1;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      pronto_q <= pronto_d;
      dados_q  <= dados_d;
      rx_s1_q  <= RX;
      rx_s2_q  <= rx_s1_q;
    end
  end

  // Bit timing and deserialisation
  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    pronto_d = 1'b0;
    dados_d  = dados_q;
    case (estado_q)
      RX_OCIOSO: begin
        cnt_d = '0;
        if (!rx_s2_q) estado_d = RX_INICIO;
      end
      RX_INICIO: begin
        if (cnt_q == MEIO_BIT) begin
          cnt_d    = '0;
          bit_d    = '0;
          estado_d = rx_s2_q ? RX_OCIOSO : RX_DADOS;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DADOS: begin
        if (cnt_q == FIM_BIT) begin
          cnt_d   = '0;
          shift_d = {rx_s2_q, shift_q[BYTE_W-1:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) estado_d = RX_PARADA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        if (cnt_q == FIM_BIT) begin
          cnt_d    = '0;
          pronto_d = rx_s2_q;
          if (rx_s2_q) dados_d = shift_q;
          estado_d = RX_OCIOSO;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  assign pronto      = pronto_q;
  assign dados_ascii = dados_q;

endmodule

// File: rtl/recepcao_comandos_multinivel.sv
// Framed command receiver: UART bytes -> threshold registers and mode/valve bits.
// Optional feature macro: RECEPCAO_CHECKSUM_EN (frame carries a 4th CK byte).
module recepcao_comandos_multinivel
  import recepcao_comandos_multinivel_pkg::*;
#(
  parameter int unsigned                    NUM_NIVEIS     = 3,
  parameter int unsigned                    DATA_W         = 12,
  parameter logic [NUM_NIVEIS*DATA_W-1:0]   INIT_VALUES    = {12'd3, 12'd12, 12'd27},
  parameter int unsigned                    TIMEOUT_CICLOS = 500000,
  parameter int unsigned                    CICLOS_POR_BIT = 434
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         RX,
  output logic [NUM_NIVEIS*DATA_W-1:0] niveis,
  output logic                         manual,
  output logic                         abrir_valv,
  output logic                         atualizado,
  output logic                         erro,
  output logic [1:0]                   db_estado
);

  localparam int unsigned       NW      = NUM_NIVEIS * DATA_W;
  localparam int unsigned       TO_W    = $clog2(TIMEOUT_CICLOS);
  localparam logic [TO_W-1:0]   TO_LIM  = TO_W'(TIMEOUT_CICLOS - 1);
  localparam logic [5:0]        NUM_IDX = 6'(NUM_NIVEIS);

  logic              pronto;
  logic [BYTE_W-1:0] dados_ascii;

  estado_t              estado_q, estado_d;
  logic [TO_W-1:0]      cnt_q, cnt_d;
  logic [5:0]           idx_q, idx_d;
  logic [PAYLOAD_W-1:0] dh_q, dh_d;
  logic [NW-1:0]        niveis_q, niveis_d;
  logic                 manual_q, manual_d;
  logic                 valv_q, valv_d;
  logic                 atualizado_q, atualizado_d;
  logic                 erro_q, erro_d;
  logic                 commit_c;
  logic [VALOR_W-1:0]   valor_c;
  classe_t              classe_c;
`ifdef RECEPCAO_CHECKSUM_EN
  logic [PAYLOAD_W-1:0] dl_q, dl_d;
  logic [BYTE_W-1:0]    ck_c;
`endif

  rx_serial_8N1 #(
    .CICLOS_POR_BIT(CICLOS_POR_BIT)
  ) u_rx (
    .clock       (clock),
    .reset       (reset),
    .RX          (RX),
    .pronto      (pronto),
    .dados_ascii (dados_ascii)
  );

  // Frame state, timeout counter and register bank
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q     <= OCIOSO;
      cnt_q        <= '0;
      idx_q        <= '0;
      dh_q         <= '0;
      niveis_q     <= INIT_VALUES;
      manual_q     <= 1'b0;
      valv_q       <= 1'b0;
      atualizado_q <= 1'b0;
      erro_q       <= 1'b0;
`ifdef RECEPCAO_CHECKSUM_EN
      dl_q         <= '0;
`endif
    end else begin
      estado_q     <= estado_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      dh_q         <= dh_d;
      niveis_q     <= niveis_d;
      manual_q     <= manual_d;
      valv_q       <= valv_d;
      atualizado_q <= atualizado_d;
      erro_q       <= erro_d;
`ifdef RECEPCAO_CHECKSUM_EN
      dl_q         <= dl_d;
`endif
    end
  end

  // Frame parsing, resync/timeout handling and commit
  always_comb begin
    estado_d     = estado_q;
    idx_d        = idx_q;
    dh_d         = dh_q;
    niveis_d     = niveis_q;
    manual_d     = manual_q;
    valv_d       = valv_q;
    atualizado_d = 1'b0;
    erro_d       = 1'b0;
    commit_c     = 1'b0;
    cnt_d        = (pronto || estado_q == OCIOSO) ? '0 : cnt_q + 1'b1;
    classe_c     = classifica_byte(dados_ascii);
`ifdef RECEPCAO_CHECKSUM_EN
    dl_d    = dl_q;
    valor_c = {dh_q, dl_q};
    ck_c    = ({HDR_MARK, 1'b0, idx_q} ^ {2'b00, dh_q} ^ {2'b00, dl_q}) & MASK_CK;
`else
    valor_c = {dh_q, dados_ascii[PAYLOAD_W-1:0]};
`endif

    if (pronto) begin
      case (estado_q)
        OCIOSO: begin
          if (classe_c == BYTE_HDR) begin
            estado_d = DADO_ALTO;
            idx_d    = dados_ascii[5:0];
          end else begin
            erro_d = 1'b1;
          end
        end
        DADO_ALTO, DADO_BAIXO: begin
          case (classe_c)
            BYTE_HDR: begin
              erro_d   = 1'b1;
              estado_d = DADO_ALTO;
              idx_d    = dados_ascii[5:0];
            end
            BYTE_INVAL: begin
              erro_d   = 1'b1;
              estado_d = OCIOSO;
            end
            default: begin
              if (estado_q == DADO_ALTO) begin
                dh_d     = dados_ascii[PAYLOAD_W-1:0];
                estado_d = DADO_BAIXO;
              end else begin
`ifdef RECEPCAO_CHECKSUM_EN
                dl_d     = dados_ascii[PAYLOAD_W-1:0];
                estado_d = CHECKSUM;
`else
                commit_c = 1'b1;
                estado_d = OCIOSO;
`endif
              end
            end
          endcase
        end
        default: begin
          estado_d = OCIOSO;
`ifdef RECEPCAO_CHECKSUM_EN
          if (dados_ascii == ck_c) commit_c = 1'b1;
          else                     erro_d   = 1'b1;
`endif
        end
      endcase
    end else if (estado_q != OCIOSO && cnt_q == TO_LIM) begin
      estado_d = OCIOSO;
      erro_d   = 1'b1;
    end

    if (commit_c) begin
      if (idx_q < NUM_IDX) begin
        for (int unsigned i = 0; i < NUM_NIVEIS; i++) begin
          if (idx_q == 6'(i)) niveis_d[i*DATA_W +: DATA_W] = valor_c[DATA_W-1:0];
        end
        atualizado_d = 1'b1;
      end else if (idx_q == IDX_MODO) begin
        manual_d     = valor_c[1];
        valv_d       = valor_c[0];
        atualizado_d = 1'b1;
      end else begin
        erro_d = 1'b1;
      end
    end
  end

  assign niveis     = niveis_q;
  assign manual     = manual_q;
  assign abrir_valv = valv_q;
  assign atualizado = atualizado_q;
  assign erro       = erro_q;
  assign db_estado  = estado_q;

endmodule

// File: tb/tb_recepcao_comandos_multinivel.sv
// Scoreboard bench for recepcao_comandos_multinivel: a byte-list frame model
// predicts every atualizado/erro pulse; a monitor checks them as they appear.
module tb_recepcao_comandos_multinivel;

  localparam int unsigned NUM_NIVEIS = 3;
  localparam int unsigned DATA_W     = 12;
  localparam int unsigned NW         = NUM_NIVEIS * DATA_W;
  localparam int unsigned TIMEOUT    = 100;
  localparam int unsigned CPB        = 6;
  localparam logic [NW-1:0] INIT     = {12'd3, 12'd12, 12'd27};
`ifdef RECEPCAO_CHECKSUM_EN
  localparam int FRAME_LEN = 4;
`else
  localparam int FRAME_LEN = 3;
`endif

  logic          clock, reset, RX;
  logic [NW-1:0] niveis;
  logic          manual, abrir_valv, atualizado, erro;
  logic [1:0]    db_estado;

  recepcao_comandos_multinivel #(
    .NUM_NIVEIS     (NUM_NIVEIS),
    .DATA_W         (DATA_W),
    .INIT_VALUES    (INIT),
    .TIMEOUT_CICLOS (TIMEOUT),
    .CICLOS_POR_BIT (CPB)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .RX         (RX),
    .niveis     (niveis),
    .manual     (manual),
    .abrir_valv (abrir_valv),
    .atualizado (atualizado),
    .erro       (erro),
    .db_estado  (db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit            upd;
    logic [NW-1:0] niv;
    bit            man;
    bit            valv;
    logic [1:0]    est;
  } exp_t;

  exp_t              exp_q[$];
  logic [7:0]        part[$];
  logic [DATA_W-1:0] m_niv[NUM_NIVEIS];
  bit                m_man, m_valv;
  int                n_cmp = 0;
  int                n_err = 0;

  function automatic logic [NW-1:0] pack_niv();
    logic [NW-1:0] r;
    for (int i = 0; i < NUM_NIVEIS; i++) r[i*DATA_W +: DATA_W] = m_niv[i];
    return r;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NUM_NIVEIS; i++) m_niv[i] = INIT[i*DATA_W +: DATA_W];
    m_man  = 1'b0;
    m_valv = 1'b0;
    part.delete();
    exp_q.delete();
  endfunction

  function automatic void push_ev(input bit upd, input logic [1:0] est);
    exp_t e;
    e.upd  = upd;
    e.niv  = pack_niv();
    e.man  = m_man;
    e.valv = m_valv;
    e.est  = est;
    exp_q.push_back(e);
  endfunction

  // Completed frame: apply it to the model register file
  function automatic void model_commit();
    int idx, v;
    idx = int'(part[0][5:0]);
    v   = int'(part[1][5:0]) * 64 + int'(part[2][5:0]);
    if (idx < NUM_NIVEIS) begin
      m_niv[idx] = DATA_W'(v % (1 << DATA_W));
      push_ev(1'b1, 2'd0);
    end else if (idx == 63) begin
      m_man  = ((v / 2) % 2) == 1;
      m_valv = (v % 2) == 1;
      push_ev(1'b1, 2'd0);
    end else begin
      push_ev(1'b0, 2'd0);
    end
  endfunction

  // Frame rules applied to the list of bytes received so far
  function automatic void model_byte(input logic [7:0] b);
    bit hdr, bad;
    hdr = (b[7] == 1'b1) && (b[6] == 1'b0);
    bad = b[6];
`ifdef RECEPCAO_CHECKSUM_EN
    if (part.size() == 3) begin
      if (b == ((part[0] ^ part[1] ^ part[2]) & 8'h7F)) model_commit();
      else push_ev(1'b0, 2'd0);
      part.delete();
      return;
    end
`endif
    if (part.size() == 0) begin
      if (hdr) part.push_back(b);
      else push_ev(1'b0, 2'd0);
    end else if (hdr) begin
      part.delete();
      part.push_back(b);
      push_ev(1'b0, 2'd1);
    end else if (bad) begin
      part.delete();
      push_ev(1'b0, 2'd0);
    end else begin
      part.push_back(b);
      if (FRAME_LEN == 3 && part.size() == 3) begin
        model_commit();
        part.delete();
      end
    end
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, expv);
    end
  endtask

  task automatic uart_tx(input logic [7:0] b);
    RX = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (CPB) @(negedge clock);
    end
    RX = 1'b1;
    repeat (CPB) @(negedge clock);
  endtask

  task automatic send(input logic [7:0] b);
    model_byte(b);
    uart_tx(b);
    repeat ($urandom_range(0, 15)) @(negedge clock);
  endtask

  task automatic long_idle();
    if (part.size() != 0) push_ev(1'b0, 2'd0);
    part.delete();
    repeat (TIMEOUT + 50) @(negedge clock);
  endtask

  task automatic send_frame(input logic [5:0] idx, input logic [11:0] v, input bit bad_ck);
    logic [7:0] h, dh, dl, ck;
    h  = {2'b10, idx};
    dh = {2'b00, v[11:6]};
    dl = {2'b00, v[5:0]};
    ck = (h ^ dh ^ dl) & 8'h7F;
    send(h);
    send(dh);
    send(dl);
`ifdef RECEPCAO_CHECKSUM_EN
    send(bad_ck ? (ck ^ 8'h01) : ck);
`else
    if (bad_ck) ck = 8'h00;
`endif
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge clock);
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_state();
    chk("rst_niveis", 64'(niveis), 64'(INIT));
    chk("rst_manual", 64'(manual), 64'd0);
    chk("rst_valv", 64'(abrir_valv), 64'd0);
    chk("rst_estado", 64'(db_estado), 64'd0);
    chk("rst_pulses", 64'({atualizado, erro}), 64'd0);
  endtask

  // Monitor: every pulse must match the next predicted event
  always @(negedge clock) begin
    if (!reset && (atualizado || erro)) begin
      exp_t e;
      n_cmp++;
      if (atualizado && erro) begin
        n_err++;
        $display("FAIL both_pulses got atualizado=1 erro=1 required one-hot");
      end else if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_pulse got atualizado=%0b erro=%0b required none", atualizado, erro);
      end else begin
        e = exp_q.pop_front();
        if (atualizado !== e.upd || niveis !== e.niv || manual !== e.man ||
            abrir_valv !== e.valv || db_estado !== e.est) begin
          n_err++;
          $display("FAIL pulse_event got upd=%0b niv=%0h man=%0b valv=%0b est=%0d required upd=%0b niv=%0h man=%0b valv=%0b est=%0d",
                   atualizado, niveis, manual, abrir_valv, db_estado,
                   e.upd, e.niv, e.man, e.valv, e.est);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    RX    = 1'b1;
    reset = 1'b1;
    model_reset();
    repeat (4) @(negedge clock);
    check_reset_state();
    reset = 1'b0;
    repeat (20) @(negedge clock);
    check_reset_state();

    send(8'h81); send(8'h01); send(8'h05);
`ifdef RECEPCAO_CHECKSUM_EN
    send(8'h05);
`endif
    drain();
    chk("nivel1_69", 64'(niveis[DATA_W +: DATA_W]), 64'd69);

    send_frame(6'd63, 12'd3, 1'b0);
    drain();
    chk("modo_manual", 64'({manual, abrir_valv}), 64'b11);

    send(8'h80); send(8'h01);
    send_frame(6'd2, 12'd7, 1'b0);
    drain();
    chk("resync_nivel2", 64'(niveis[2*DATA_W +: DATA_W]), 64'd7);
    chk("resync_nivel0", 64'(niveis[DATA_W-1:0]), 64'd27);

    send(8'h80); send(8'h02);
    long_idle();
    chk("timeout_estado", 64'(db_estado), 64'd0);
    send(8'h05);
    drain();
    chk("timeout_nivel0", 64'(niveis[DATA_W-1:0]), 64'd27);

    send_frame(6'd5, 12'd1, 1'b0);
    drain();

`ifdef RECEPCAO_CHECKSUM_EN
    send(8'h80); send(8'h00); send(8'h09); send(8'h09);
    drain();
    chk("ck_ok_nivel0", 64'(niveis[DATA_W-1:0]), 64'd9);
    send(8'h80); send(8'h00); send(8'h05); send(8'h08);
    drain();
    chk("ck_bad_nivel0", 64'(niveis[DATA_W-1:0]), 64'd9);
`endif

    // Reset drops a partial frame; the tail byte is then stray
    send(8'h81); send(8'h02);
    repeat (10) @(negedge clock);
    reset = 1'b1;
    model_reset();
    repeat (3) @(negedge clock);
    check_reset_state();
    reset = 1'b0;
    send(8'h07);
    drain();
    chk("post_reset_nivel1", 64'(niveis[DATA_W +: DATA_W]), 64'd12);

    for (int k = 0; k < 40; k++) begin
      int sel;
      sel = $urandom_range(0, 8);
      case (sel)
        0, 1, 2: send_frame(6'($urandom_range(0, NUM_NIVEIS - 1)), 12'($urandom), ($urandom_range(0, 5) == 0));
        3: send_frame(6'd63, 12'($urandom), 1'b0);
        4: send_frame(6'($urandom_range(NUM_NIVEIS, 62)), 12'($urandom), 1'b0);
        5: begin
          send({2'b10, 6'($urandom)});
          if ($urandom_range(0, 1) == 1) send({2'b00, 6'($urandom)});
          send_frame(6'($urandom_range(0, NUM_NIVEIS - 1)), 12'($urandom), 1'b0);
        end
        6: begin
          send({2'b10, 6'($urandom_range(0, NUM_NIVEIS - 1))});
          send({1'($urandom), 1'b1, 6'($urandom)});
        end
        7: begin
          send({2'b10, 6'($urandom_range(0, NUM_NIVEIS - 1))});
          if ($urandom_range(0, 1) == 1) send({2'b00, 6'($urandom)});
          long_idle();
        end
        default: send({2'b00, 6'($urandom)});
      endcase
    end
    drain();
    chk("final_niveis", 64'(niveis), 64'(pack_niv()));
    chk("final_modo", 64'({manual, abrir_valv}), 64'({m_man, m_valv}));
    chk("final_estado", 64'(db_estado), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
